// File: rtl/channel_accum_activate.sv
// Sums CHANNELS conv-transpose buffers plus bias, applies activation, stores a feature map.
// Define ACC_SATURATE_EN to clamp the channel sum; otherwise the sum wraps to W bits.
module channel_accum_activate #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned INT_W        = 10,
    parameter int unsigned FRAC_W       = 10,
    parameter int unsigned TOTAL_OUTPUT = 900,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      act_mode,
    input  logic [INT_W+FRAC_W-1:0]         bias,
    output logic [ADDR_W-1:0]               ch_addr,
    output logic                            ch_en,
    input  logic [CHANNELS*(INT_W+FRAC_W)-1:0] ch_data,
    input  logic [ADDR_W-1:0]               out_addr,
    input  logic                            out_en,
    output logic [INT_W+FRAC_W-1:0]         out_data,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned W = INT_W + FRAC_W;
`ifdef ACC_SATURATE_EN
    localparam int unsigned SUM_W = W + $clog2(CHANNELS + 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SUM_W'(2 ** (W - 1));
`else
    // Wrapping keeps only the low W bits, and modular addition in W bits gives exactly those.
    localparam int unsigned SUM_W = W;
`endif
    localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(TOTAL_OUTPUT - 1);
    localparam logic [3:0]          WAIT_END = 4'(READ_LATENCY - 1);
    localparam logic signed [W:0]   HS_HALF  = (W + 1)'(1) << (FRAC_W - 1);
    localparam logic signed [W:0]   HS_ONE   = (W + 1)'(1) << FRAC_W;

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StSum, StAct, StWrite, StNext, StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]      idx_q;
    logic [3:0]             wait_q;
    logic [1:0]             mode_q;
    logic signed [W-1:0]    bias_q;
    logic signed [W-1:0]    sum_q;
    logic [W-1:0]           act_q;
    logic signed [SUM_W-1:0] acc;
    logic signed [W-1:0]    sum_red;
    logic signed [W:0]      hs_shift;
    logic signed [W:0]      hs_val;
    logic [W-1:0]           act_val;
    logic [W-1:0]           mem [TOTAL_OUTPUT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StIssue;
            StIssue:        state_d = StWait;
            StWait:         if (wait_q == WAIT_END) state_d = StSum;
            StSum:          state_d = StAct;
            StAct:          state_d = StWrite;
            StWrite:        state_d = StNext;
            StNext:         state_d = (idx_q < LAST_IDX) ? StIssue : StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        ch_en   = (state_q == StIssue);
        ch_addr = (state_q == StIssue) ? idx_q : '0;
        busy    = (state_q != StIdle) && (state_q != StDone);
        done    = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= '0;
            wait_q <= '0;
            mode_q <= '0;
            bias_q <= '0;
            sum_q  <= '0;
            act_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Mode and bias are frozen for the whole pass.
                    if (start) begin
                        idx_q  <= '0;
                        mode_q <= act_mode;
                        bias_q <= bias;
                    end
                end
                StIssue: wait_q <= '0;
                StWait:  wait_q <= wait_q + 4'd1;
                StSum:   sum_q  <= sum_red;
                StAct:   act_q  <= act_val;
                StNext:  if (idx_q < LAST_IDX) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        acc = SUM_W'(bias_q);
        for (int c = 0; c < CHANNELS; c++) begin
            acc = acc + SUM_W'($signed(ch_data[c*W +: W]));
        end
`ifdef ACC_SATURATE_EN
        if (acc > SAT_MAX) begin
            sum_red = SAT_MAX[W-1:0];
        end else if (acc < SAT_MIN) begin
            sum_red = SAT_MIN[W-1:0];
        end else begin
            sum_red = acc[W-1:0];
        end
`else
        sum_red = acc;
`endif
    end

    always_comb begin
        hs_shift = $signed({sum_q[W-1], sum_q}) >>> 2;
        hs_val   = hs_shift + HS_HALF;
        act_val  = sum_q;
        case (mode_q)
            2'd1: act_val = sum_q[W-1] ? '0 : sum_q;
            2'd2: begin
                if (hs_val < 0) begin
                    act_val = '0;
                end else if (hs_val > HS_ONE) begin
                    act_val = HS_ONE[W-1:0];
                end else begin
                    act_val = hs_val[W-1:0];
                end
            end
            default: act_val = sum_q;
        endcase
    end

    // Output memory is deliberately not reset; every pass rewrites all entries.
    always_ff @(posedge clk) begin
        if (state_q == StWrite) mem[idx_q] <= act_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data <= '0;
        end else if (out_en && (state_q == StDone)) begin
            out_data <= (32'(out_addr) < TOTAL_OUTPUT) ? mem[out_addr] : '0;
        end
    end

endmodule

// File: tb/tb_channel_accum_activate.sv
// Scoreboard bench for channel_accum_activate: expected values queued at start, popped on readback.
module tb_channel_accum_activate;

    localparam int N = 900;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  act_mode = 2'd0;
    logic [19:0] bias = '0;
    logic [9:0]  ch_addr;
    logic        ch_en;
    logic [39:0] ch_data;
    logic [9:0]  out_addr = '0;
    logic        out_en = 1'b0;
    logic [19:0] out_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic signed [19:0] ch0_mem [N];
    logic signed [19:0] ch1_mem [N];
    logic [39:0]        pipe [4];
    logic [19:0]        exp_q [$];

    channel_accum_activate dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .act_mode (act_mode),
        .bias     (bias),
        .ch_addr  (ch_addr),
        .ch_en    (ch_en),
        .ch_data  (ch_data),
        .out_addr (out_addr),
        .out_en   (out_en),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Channel buffers: four-cycle read latency, output held until the next read arrives.
    always @(posedge clk) begin
        if (ch_en) pipe[0] <= {ch1_mem[ch_addr], ch0_mem[ch_addr]};
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign ch_data = pipe[3];

    function automatic logic [19:0] model(input logic signed [19:0] c0, input logic signed [19:0] c1,
                                          input logic signed [19:0] b, input logic [1:0] m);
        longint s, r, h;
        s = longint'(c0) + longint'(c1) + longint'(b);
`ifdef ACC_SATURATE_EN
        if (s > 524287) r = 524287;
        else if (s < -524288) r = -524288;
        else r = s;
`else
        r = s & 64'hFFFFF;
        if (r >= 524288) r = r - 1048576;
`endif
        case (m)
            2'd1: if (r < 0) r = 0;
            2'd2: begin
                h = (r >>> 2) + 512;
                if (h < 0) h = 0;
                if (h > 1024) h = 1024;
                r = h;
            end
            default: ;
        endcase
        return r[19:0];
    endfunction

    task automatic fill_const(input int a0, input int a1);
        for (int a = 0; a < N; a++) begin
            ch0_mem[a] = 20'(a0);
            ch1_mem[a] = 20'(a1);
        end
    endtask

    task automatic fill_random();
        int v;
        for (int a = 0; a < N; a++) begin
            v = int'($urandom_range(0, 262143)) - 131072;
            ch0_mem[a] = v[19:0];
            v = int'($urandom_range(0, 262143)) - 131072;
            ch1_mem[a] = v[19:0];
        end
    endtask

    task automatic start_pass(input logic [1:0] m, input logic [19:0] b);
        @(negedge clk);
        act_mode = m;
        bias = b;
        start = 1'b1;
        for (int a = 0; a < N; a++) exp_q.push_back(model(ch0_mem[a], ch1_mem[a], b, m));
        @(negedge clk);
        start = 1'b0;
        // Scramble so a design that does not hold its sampled mode/bias diverges.
        act_mode = ~m;
        bias = b ^ 20'h5A5A5;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s wait_done: done=%0b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic readback_all(input string name);
        logic [19:0] e;
        @(negedge clk);
        out_en = 1'b1;
        out_addr = '0;
        for (int a = 1; a <= N; a++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            checks++;
            if (out_data !== e) begin
                errors++;
                $display("FAIL %s addr %0d: got %0d required %0d", name, a - 1,
                         $signed(out_data), $signed(e));
            end
            if (a < N) out_addr = 10'(a);
        end
        out_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ch_en, ch_addr, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b ch_en=%0b ch_addr=%0d out_data=%0d required all 0",
                     busy, done, ch_en, ch_addr, out_data);
        end
        reset = 1'b1;
        out_en = 1'b1;
        out_addr = 10'd5;
        repeat (2) @(negedge clk);
        out_en = 1'b0;
        checks++;
        if (out_data !== 20'd0) begin
            errors++;
            $display("FAIL readback_not_done: got %0d required 0", out_data);
        end
    endtask

    task automatic test_relu_timing();
        int cyc, en_cnt, busy_cnt, done_cyc;
        fill_const(512, 256);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %0b required 0", busy);
        end
        start_pass(2'd1, 20'd256);
        cyc = 1;
        en_cnt = 0;
        busy_cnt = 0;
        done_cyc = -1;
        while (cyc < 9000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
            if (ch_en) en_cnt++;
            start = (cyc == 4000);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (done_cyc != 1 + N * 9) begin
            errors++;
            $display("FAIL done_cycle: got %0d required %0d", done_cyc, 1 + N * 9);
        end
        checks++;
        if (busy_cnt != N * 9) begin
            errors++;
            $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, N * 9);
        end
        checks++;
        if (en_cnt != N) begin
            errors++;
            $display("FAIL ch_en_pulses: got %0d required %0d", en_cnt, N);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %0b required 0", busy);
        end
        readback_all("relu_const");
    endtask

    task automatic test_readback_edges();
        @(negedge clk);
        out_en = 1'b1;
        out_addr = 10'd5;
        @(negedge clk);
        checks++;
        if (out_data !== 20'd1024) begin
            errors++;
            $display("FAIL readback_addr5: got %0d required 1024", out_data);
        end
        out_addr = 10'd950;
        @(negedge clk);
        checks++;
        if (out_data !== 20'd0) begin
            errors++;
            $display("FAIL readback_out_of_range: got %0d required 0", out_data);
        end
        out_en = 1'b0;
        out_addr = 10'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (out_data !== 20'd0) begin
            errors++;
            $display("FAIL readback_hold: got %0d required 0", out_data);
        end
    endtask

    task automatic test_modes();
        fill_random();
        ch0_mem[0] = -20'sd512;
        ch1_mem[0] = -20'sd256;
        ch0_mem[1] = 20'sd512;
        ch1_mem[1] = 20'sd256;
        start_pass(2'd0, 20'd0);
        wait_done("mode0");
        readback_all("mode0");
        start_pass(2'd2, 20'd0);
        wait_done("mode2");
        readback_all("mode2");
        start_pass(2'd3, 20'hFFC18);
        wait_done("mode3");
        readback_all("mode3");
    endtask

    task automatic test_overflow();
        for (int a = 0; a < N; a++) begin
            ch0_mem[a] = a[0] ? 20'h80000 : 20'h7FFFF;
            ch1_mem[a] = a[0] ? 20'h80000 : 20'h7FFFF;
        end
        start_pass(2'd0, 20'd1);
        wait_done("overflow");
        readback_all("overflow");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        fill_random();
        start_pass(2'd1, 20'd777);
        while (!(ch_en && ch_addr == 10'd100) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(ch_en && ch_addr == 10'd100)) begin
            errors++;
            $display("FAIL reach_element100: ch_en=%0b ch_addr=%0d required 1/100", ch_en, ch_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({busy, done, ch_en, ch_addr, out_data} !== '0) begin
            errors++;
            $display("FAIL midpass_reset: busy=%0b done=%0b ch_en=%0b ch_addr=%0d out_data=%0d required all 0",
                     busy, done, ch_en, ch_addr, out_data);
        end
        exp_q.delete();
        fill_random();
        start_pass(2'd1, 20'hFF000);
        wait_done("after_reset");
        readback_all("after_reset");
    endtask

    initial begin
        test_reset();
        test_relu_timing();
        test_readback_edges();
        test_modes();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/channel_accum_activate.md
CHANNEL_ACCUM_ACTIVATE -- requirements
Module: channel_accum_activate

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of conv-transpose channel buffers summed per output element.
REQ-002 SHALL have parameter INT_W, default 10, integer bits of signed fixed-point data.
REQ-003 SHALL have parameter FRAC_W, default 10, fraction bits; W = INT_W+FRAC_W.
REQ-004 SHALL have parameter TOTAL_OUTPUT, default 900, elements per feature map.
REQ-005 SHALL have parameter ADDR_W, default 10, address width for channel and output buffers.
REQ-006 SHALL have parameter READ_LATENCY, default 4, channel buffer read latency in cycles (1..15).
REQ-007 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port start  input  1  one-cycle pulse requesting a pass over all elements.
REQ-010 SHALL have port act_mode  input  2  0 identity, 1 ReLU, 2 hard-sigmoid, 3 identity.
REQ-011 SHALL have port bias  input  W  signed bias added to every element.
REQ-012 SHALL have port ch_addr  output  ADDR_W  read address shared by all channel buffers.
REQ-013 SHALL have port ch_en  output  1  channel buffer read enable.
REQ-014 SHALL have port ch_data  input  CHANNELS*W  packed channel data, channel c at bits [c*W +: W].
REQ-015 SHALL have port out_addr  input  ADDR_W  readback address.
REQ-016 SHALL have port out_en  input  1  readback enable.
REQ-017 SHALL have port out_data  output  W  registered readback data.
REQ-018 SHALL have port busy  output  1  high while a pass is in progress.
REQ-019 SHALL have port done  output  1  sticky pass-complete flag.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, SUM, ACT, WRITE, NEXT, DONE.
REQ-021 SHALL move IDLE or DONE -> ISSUE on start=1, clearing done, setting busy, element index 0; start SHALL be ignored in all other states.
REQ-022 ISSUE SHALL drive ch_en=1, ch_addr=index for exactly one cycle, then enter WAIT.
REQ-023 WAIT SHALL last READ_LATENCY cycles, then SUM samples ch_data.
REQ-024 SUM SHALL compute signed sum of all CHANNELS words plus bias in width W+clog2(CHANNELS+1), then reduce to W per REQ-036.
REQ-025 ACT SHALL register f(sum): identity; ReLU max(0,x); hard-sigmoid clamp((x>>>2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
REQ-026 WRITE SHALL store the activated value into internal TOTAL_OUTPUT x W memory at index.
REQ-027 NEXT SHALL increment index and go to ISSUE if index < TOTAL_OUTPUT-1, else DONE.
REQ-028 Per-element cost SHALL be exactly READ_LATENCY+5 cycles; no element pipelining.
REQ-029 DONE SHALL assert done=1, busy=0, held until next start or reset.
REQ-030 act_mode and bias SHALL be sampled once at start acceptance and held for the pass.
REQ-031 Readback SHALL be honored only when done=1: out_data = mem[out_addr] one cycle after out_en=1; otherwise out_data holds its value.
REQ-032 out_addr >= TOTAL_OUTPUT SHALL return 0.

Reset
REQ-033 reset=0 on a clock edge SHALL force IDLE, index 0, ch_en 0, ch_addr 0, out_data 0, busy 0, done 0, any state including mid-pass.
REQ-034 Output memory contents SHALL not be reset; a pass after reset SHALL fully overwrite it.

Configuration
REQ-035 Macro ACC_SATURATE_EN SHALL select sum reduction mode.
REQ-036 Defined: sum clamped to [-2^(W-1), 2^(W-1)-1]; undefined: low W bits kept (two's-complement wrap).

Verification
REQ-037 CHANNELS=2, W=20, ch0=512, ch1=256, bias=256, mode 1 -> every element reads back 1024.
REQ-038 ch0=-512, ch1=-256, bias=0: mode 1 -> 0; mode 2 -> 320; mode 0 -> -768.
REQ-039 ch0=ch1=524287, bias=1, mode 0 -> 524287 with ACC_SATURATE_EN, -1 without.
REQ-040 READ_LATENCY=4, TOTAL_OUTPUT=900, start at cycle 0 -> done rises at cycle 1+900*9, busy high in between, exactly 900 ch_en pulses.
REQ-041 reset=0 for one cycle at element 100, then start -> busy/done/ch_en 0 after reset; new pass completes with correct data.
REQ-042 After done, out_en=1, out_addr=5 -> out_data = element 5 next cycle; out_addr=950 -> 0; start while busy -> no effect.
